// File: rtl/scsa_pipe.sv
// Pipelined speculative-carry segmented adder with per-transaction approximate/exact
// mode, a 2-stage valid/ready pipeline and saturating op/error counters.
module scsa_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int NSEG = WIDTH / SEG;

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_mode;
  logic             adv1, adv2;
  logic [WIDTH:0]   approx, exact, sel;
  logic             mismatch;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Each segment's carry-in is the generate of the segment below, taken with carry-in 0.
  always_comb begin
    logic [SEG:0] seg_g;
    logic [SEG:0] seg_s;
    logic         carry;
    approx = '0;
    seg_g  = '0;
    seg_s  = '0;
    carry  = 1'b0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      seg_g = {1'b0, s1_a[i*SEG +: SEG]} + {1'b0, s1_b[i*SEG +: SEG]};
      seg_s = seg_g + {{SEG{1'b0}}, carry};
      approx[i*SEG +: SEG] = seg_s[SEG-1:0];
      carry = seg_g[SEG];
    end
    approx[WIDTH] = seg_s[SEG];
  end

  assign exact    = {1'b0, s1_a} + {1'b0, s1_b};
  assign sel      = s1_mode ? exact : approx;
  assign mismatch = !s1_mode && (approx != exact);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_mode <= mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      err      <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sel[WIDTH-1:0];
        cout <= sel[WIDTH];
        err  <= mismatch;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (clr_stats) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (s2_valid && out_ready) begin
      if (op_cnt != '1) op_cnt <= op_cnt + 1'b1;
      if (err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_scsa_pipe.sv
// Bench for scsa_pipe: directed vectors, back-pressure, stats, reset and random traffic
// against a queue-based reference model (second instance exercises counter saturation).
module tb_scsa_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, mode, out_ready, clr_stats;
  logic [7:0] a, b;

  logic        in_ready, out_valid, cout, err;
  logic [7:0]  sum;
  logic [15:0] op_cnt, err_cnt;

  logic        in_ready2, out_valid2, cout2, err2;
  logic [7:0]  sum2;
  logic [1:0]  op_cnt2, err_cnt2;

  scsa_pipe #(.WIDTH(8), .SEG(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .err(err), .clr_stats(clr_stats), .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  scsa_pipe #(.WIDTH(8), .SEG(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .cout(cout2),
    .err(err2), .clr_stats(clr_stats), .op_cnt(op_cnt2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       e;
    int         age;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int m_ops = 0, m_errs = 0, m_ops2 = 0, m_errs2 = 0;

  function automatic logic [8:0] approx_ref(input int x, input int y);
    int res = 0;
    int c = 0;
    int t = 0;
    for (int i = 0; i < 4; i++) begin
      int xi = (x >> (2 * i)) & 3;
      int yi = (y >> (2 * i)) & 3;
      if (i == 0) c = 0;
      else c = ((((x >> (2 * (i - 1))) & 3) + ((y >> (2 * (i - 1))) & 3)) >= 4) ? 1 : 0;
      t = xi + yi + c;
      res = res | ((t % 4) << (2 * i));
    end
    if (t >= 4) res = res | 256;
    return res[8:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] av, input logic [7:0] bv, input bit md,
                      input bit ordy, input bit clr, output bit acc);
    bit    exp_ov, exp_ir, out_hs;
    item_t it, nw;
    logic [8:0] ex, ap;
    in_valid = v; a = av; b = bv; mode = md; out_ready = ordy; clr_stats = clr;
    #1;
    exp_ov = (q.size() > 0) && (q[0].age >= 2);
    exp_ir = (q.size() < 2) || ordy;
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_ir);
    chk("op_cnt", op_cnt, m_ops);
    chk("err_cnt", err_cnt, m_errs);
    chk("op_cnt_sat", op_cnt2, m_ops2);
    chk("err_cnt_sat", err_cnt2, m_errs2);
    if (exp_ov) begin
      chk("sum", sum, q[0].s);
      chk("cout", cout, q[0].c);
      chk("err", err, q[0].e);
    end
    acc    = v && exp_ir;
    out_hs = exp_ov && ordy;
    @(posedge clk);
    it = '{s: 8'h00, c: 1'b0, e: 1'b0, age: 0};
    if (out_hs) it = q.pop_front();
    foreach (q[i]) q[i].age++;
    if (acc) begin
      ex = {1'b0, av} + {1'b0, bv};
      ap = approx_ref(int'(av), int'(bv));
      nw.s   = md ? ex[7:0] : ap[7:0];
      nw.c   = md ? ex[8] : ap[8];
      nw.e   = !md && (ap != ex);
      nw.age = 1;
      q.push_back(nw);
    end
    if (clr) begin
      m_ops = 0; m_errs = 0; m_ops2 = 0; m_errs2 = 0;
    end else if (out_hs) begin
      if (m_ops < 65535) m_ops++;
      if (m_ops2 < 3) m_ops2++;
      if (it.e) begin
        if (m_errs < 65535) m_errs++;
        if (m_errs2 < 3) m_errs2++;
      end
    end
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input logic [7:0] s, input logic c, input logic e);
    #1;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sum"}, sum, s);
    chk({tag, "_cout"}, cout, c);
    chk({tag, "_err"}, err, e);
  endtask

  initial begin
    bit acc;
    int sent;
    rst = 1'b1; in_valid = 0; a = 0; b = 0; mode = 0; out_ready = 0; clr_stats = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Exact agreement, latency 2
    step(1, 8'h03, 8'h01, 0, 1, 0, acc);
    step(0, 8'h00, 8'h00, 0, 1, 0, acc);
    lit("agree", 8'h04, 1'b0, 1'b0);
    step(0, 8'h00, 8'h00, 0, 1, 0, acc);

    // Speculation miss, then exact
    step(1, 8'h0F, 8'h01, 0, 1, 0, acc);
    step(1, 8'h0F, 8'h01, 1, 1, 0, acc);
    lit("miss", 8'h00, 1'b0, 1'b1);
    step(0, 8'h00, 8'h00, 0, 1, 0, acc);
    lit("miss_exact", 8'h10, 1'b0, 1'b0);
    step(0, 8'h00, 8'h00, 0, 1, 0, acc);

    // Carry-out loss, then exact
    step(1, 8'hFF, 8'h01, 0, 1, 0, acc);
    step(1, 8'hFF, 8'h01, 1, 1, 0, acc);
    lit("closs", 8'hF0, 1'b0, 1'b1);
    step(0, 8'h00, 8'h00, 0, 1, 0, acc);
    lit("closs_exact", 8'h00, 1'b1, 1'b0);
    step(0, 8'h00, 8'h00, 0, 1, 0, acc);

    // Stats: 5 results, 2 with err
    step(0, 8'h00, 8'h00, 0, 1, 1, acc);
    step(1, 8'h0F, 8'h01, 0, 1, 0, acc);
    step(1, 8'hFF, 8'h01, 0, 1, 0, acc);
    step(1, 8'h03, 8'h01, 0, 1, 0, acc);
    step(1, 8'h10, 8'h20, 1, 1, 0, acc);
    step(1, 8'h01, 8'h01, 0, 1, 0, acc);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 0, 1, 0, acc);
    #1;
    chk("stats_op_cnt", op_cnt, 5);
    chk("stats_err_cnt", err_cnt, 2);
    chk("stats_op_cnt_sat", op_cnt2, 3);
    chk("stats_err_cnt_sat", err_cnt2, 2);

    // Clear coinciding with an output handshake
    step(1, 8'h0F, 8'h01, 0, 1, 0, acc);
    step(0, 8'h00, 8'h00, 0, 1, 0, acc);
    step(0, 8'h00, 8'h00, 0, 1, 1, acc);
    #1;
    chk("clr_op_cnt", op_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);

    // Back-pressure: 4 transactions, out_ready low for 3 cycles
    sent = 0;
    for (int cyc = 0; cyc < 20 && sent < 4; cyc++) begin
      step(1, 8'($urandom), 8'($urandom), 1'($urandom), cyc >= 3, 0, acc);
      if (acc) sent++;
    end
    chk("bp_sent", sent, 4);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 1, 0, acc);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, acc);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 1, 0, acc);

    // Async reset with both stages full
    step(1, 8'h12, 8'h34, 0, 0, 0, acc);
    step(1, 8'h56, 8'h78, 1, 0, 0, acc);
    #1;
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 0;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_op_cnt", op_cnt, 0);
    chk("arst_err_cnt", err_cnt, 0);
    q.delete();
    m_ops = 0; m_errs = 0; m_ops2 = 0; m_errs2 = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 1, 0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
